// File: rtl/modbus_scan_scheduler.sv
`timescale 1ns / 1ps
// Master-mode poll sequencer: walks the scan table, issues one request per entry,
// retries on error/timeout and paces full passes by a millisecond period timer.
module modbus_scan_scheduler #(
  parameter int unsigned MS_DIV   = 50000,
  parameter int unsigned SCAN_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_en,
  input  logic [7:0]  scan_count,
  input  logic [3:0]  scan_retry_max,
  input  logic [15:0] scan_period_ms,
  input  logic [15:0] resp_to_ms,
  output logic        req_valid,
  output logic [7:0]  req_idx,
  input  logic        req_ready,
  input  logic        rsp_ok,
  input  logic        rsp_err,
  output logic        busy,
  output logic        cycle_done,
  output logic [15:0] scan_cycles_done,
  output logic [15:0] scan_err_count
);

  localparam int unsigned PW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(MS_DIV - 1);
  localparam logic [8:0] ScanMax = 9'(SCAN_MAX);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StNext, StPeriod} state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [15:0]   ms_q;
  logic [3:0]    retry_q;

  logic        tick;
  logic [15:0] to_ms;
  logic        timeout;
  logic [8:0]  cnt_eff;
  logic        last_entry;
  logic        entry_fail;
  logic        retry_left;

  always_comb begin
    tick       = (presc_q == PrescLast);
    to_ms      = (resp_to_ms == 16'd0) ? 16'd1 : resp_to_ms;
    // Fires on the cycle ending exactly to_ms*MS_DIV cycles after the handshake.
    timeout    = tick && (ms_q == to_ms - 16'd1);
    cnt_eff    = ({1'b0, scan_count} > ScanMax) ? ScanMax : {1'b0, scan_count};
    last_entry = ({1'b0, req_idx} + 9'd1) >= cnt_eff;
    // Error beats a simultaneous ok; any response beats a simultaneous timeout.
    entry_fail = rsp_err || (timeout && !rsp_ok);
    retry_left = retry_q < scan_retry_max;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      presc_q          <= '0;
      ms_q             <= '0;
      retry_q          <= '0;
      req_valid        <= 1'b0;
      req_idx          <= '0;
      busy             <= 1'b0;
      cycle_done       <= 1'b0;
      scan_cycles_done <= '0;
      scan_err_count   <= '0;
    end else begin
      cycle_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (scan_en && (scan_count != 8'd0)) begin
            state_q   <= StIssue;
            req_idx   <= '0;
            retry_q   <= '0;
            req_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StIssue: begin
          if (req_ready) begin
            state_q   <= StWait;
            req_valid <= 1'b0;
            presc_q   <= '0;
            ms_q      <= '0;
          end else if (!scan_en) begin
            state_q   <= StIdle;
            req_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        StWait: begin
          if (entry_fail) begin
            if (retry_left) begin
              retry_q   <= retry_q + 4'd1;
              state_q   <= StIssue;
              req_valid <= 1'b1;
            end else begin
              if (scan_err_count != 16'hFFFF) scan_err_count <= scan_err_count + 16'd1;
              state_q <= StNext;
            end
          end else if (rsp_ok) begin
            state_q <= StNext;
          end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick && (ms_q != 16'hFFFF)) ms_q <= ms_q + 16'd1;
          end
        end
        StNext: begin
          if (!scan_en) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (last_entry) begin
            cycle_done       <= 1'b1;
            scan_cycles_done <= scan_cycles_done + 16'd1;
            presc_q          <= '0;
            ms_q             <= '0;
            state_q          <= StPeriod;
          end else begin
            req_idx   <= req_idx + 8'd1;
            retry_q   <= '0;
            req_valid <= 1'b1;
            state_q   <= StIssue;
          end
        end
        StPeriod: begin
          if (!scan_en) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (ms_q >= scan_period_ms) begin
            req_idx   <= '0;
            retry_q   <= '0;
            req_valid <= 1'b1;
            state_q   <= StIssue;
          end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick && (ms_q != 16'hFFFF)) ms_q <= ms_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_scan_scheduler.sv
`timescale 1ns / 1ps
// Directed bench for modbus_scan_scheduler with MS_DIV=4; expected values are hand-derived.
module tb_modbus_scan_scheduler;

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic [7:0]  scan_count;
  logic [3:0]  scan_retry_max;
  logic [15:0] scan_period_ms;
  logic [15:0] resp_to_ms;
  logic        req_valid;
  logic [7:0]  req_idx;
  logic        req_ready;
  logic        rsp_ok;
  logic        rsp_err;
  logic        busy;
  logic        cycle_done;
  logic [15:0] scan_cycles_done;
  logic [15:0] scan_err_count;

  int vectors;
  int miscompares;

  modbus_scan_scheduler #(
    .MS_DIV  (4),
    .SCAN_MAX(16)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .scan_en         (scan_en),
    .scan_count      (scan_count),
    .scan_retry_max  (scan_retry_max),
    .scan_period_ms  (scan_period_ms),
    .resp_to_ms      (resp_to_ms),
    .req_valid       (req_valid),
    .req_idx         (req_idx),
    .req_ready       (req_ready),
    .rsp_ok          (rsp_ok),
    .rsp_err         (rsp_err),
    .busy            (busy),
    .cycle_done      (cycle_done),
    .scan_cycles_done(scan_cycles_done),
    .scan_err_count  (scan_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!req_valid && n < 200) begin
      step(1);
      n++;
    end
    if (!req_valid) chk("req_wait_expired", {31'd0, req_valid}, 32'd1);
  endtask

  // Entered with req_valid & req_ready high: handshake on the next edge,
  // response sampled k edges after the handshake.
  task automatic respond(input int k, input logic ok, input logic err);
    step(1);
    if (k > 1) step(k - 1);
    rsp_ok  = ok;
    rsp_err = err;
    step(1);
    rsp_ok  = 1'b0;
    rsp_err = 1'b0;
  endtask

  task automatic do_reset();
    scan_en = 1'b0;
    rsp_ok  = 1'b0;
    rsp_err = 1'b0;
    rst_n   = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  int n;

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst_n          = 1'b0;
    scan_en        = 1'b0;
    scan_count     = 8'd0;
    scan_retry_max = 4'd0;
    scan_period_ms = 16'd0;
    resp_to_ms     = 16'd100;
    req_ready      = 1'b0;
    rsp_ok         = 1'b0;
    rsp_err        = 1'b0;
    #1;
    chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_cycles", {16'd0, scan_cycles_done}, 32'd0);
    chk("rst_errs", {16'd0, scan_err_count}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // 1: three-entry pass, period 2 ms, answers 5 cycles after handshake
    scan_count     = 8'd3;
    scan_period_ms = 16'd2;
    scan_en        = 1'b1;
    wait_req(n);
    chk("t1_idx0", {24'd0, req_idx}, 32'd0);
    step(3);
    chk("t1_hold_valid", {31'd0, req_valid}, 32'd1);
    chk("t1_hold_idx", {24'd0, req_idx}, 32'd0);
    req_ready = 1'b1;
    respond(5, 1'b1, 1'b0);
    for (int i = 1; i < 3; i++) begin
      wait_req(n);
      chk("t1_next_lat", n, 32'd1);
      chk("t1_idx", {24'd0, req_idx}, i);
      respond(5, 1'b1, 1'b0);
    end
    step(1);
    chk("t1_cycle_done", {31'd0, cycle_done}, 32'd1);
    chk("t1_cycles", {16'd0, scan_cycles_done}, 32'd1);
    step(1);
    chk("t1_pulse_end", {31'd0, cycle_done}, 32'd0);
    wait_req(n);
    chk("t1_period_gap", n + 1, 32'd9);
    chk("t1_wrap_idx", {24'd0, req_idx}, 32'd0);

    // 2: entry 1 never answered, two retries, 3 ms timeout
    do_reset();
    scan_retry_max = 4'd2;
    resp_to_ms     = 16'd3;
    scan_period_ms = 16'd0;
    scan_en        = 1'b1;
    wait_req(n);
    respond(2, 1'b1, 1'b0);
    wait_req(n);
    for (int a = 0; a < 3; a++) begin
      chk("t2_retry_idx", {24'd0, req_idx}, 32'd1);
      step(1);
      wait_req(n);
      if (a < 2) begin
        chk("t2_timeout_lat", n, 32'd12);
        chk("t2_err_pending", {16'd0, scan_err_count}, 32'd0);
      end else begin
        chk("t2_final_lat", n, 32'd13);
        chk("t2_next_idx", {24'd0, req_idx}, 32'd2);
        chk("t2_err_count", {16'd0, scan_err_count}, 32'd1);
      end
    end

    // 3: one retry; ok+err together counts as error, then ok
    do_reset();
    scan_retry_max = 4'd1;
    resp_to_ms     = 16'd100;
    scan_count     = 8'd2;
    scan_en        = 1'b1;
    wait_req(n);
    respond(2, 1'b1, 1'b1);
    wait_req(n);
    chk("t3_retry_lat", n, 32'd0);
    chk("t3_retry_idx", {24'd0, req_idx}, 32'd0);
    respond(2, 1'b1, 1'b0);
    wait_req(n);
    chk("t3_next_lat", n, 32'd1);
    chk("t3_next_idx", {24'd0, req_idx}, 32'd1);
    chk("t3_err_count", {16'd0, scan_err_count}, 32'd0);

    // 4: scan_en drops during WAIT, outcome still processed
    do_reset();
    scan_retry_max = 4'd0;
    scan_count     = 8'd3;
    scan_en        = 1'b1;
    wait_req(n);
    step(1);
    scan_en = 1'b0;
    step(3);
    chk("t4_busy_wait", {31'd0, busy}, 32'd1);
    rsp_ok = 1'b1;
    step(1);
    rsp_ok = 1'b0;
    chk("t4_busy_next", {31'd0, busy}, 32'd1);
    step(1);
    chk("t4_busy_idle", {31'd0, busy}, 32'd0);
    step(10);
    chk("t4_no_req", {31'd0, req_valid}, 32'd0);

    // 5: resp_to_ms=0 acts as 1 ms; async reset mid-WAIT with 5 errors
    do_reset();
    resp_to_ms = 16'd0;
    scan_count = 8'd8;
    scan_en    = 1'b1;
    wait_req(n);
    step(1);
    wait_req(n);
    chk("t5_to0_lat", n, 32'd5);
    chk("t5_to0_idx", {24'd0, req_idx}, 32'd1);
    n = 0;
    while (scan_err_count != 16'd5 && n < 400) begin
      step(1);
      n++;
    end
    chk("t5_err5", {16'd0, scan_err_count}, 32'd5);
    wait_req(n);
    step(2);
    chk("t5_mid_wait_busy", {31'd0, busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_errs", {16'd0, scan_err_count}, 32'd0);
    chk("t5_async_idx", {24'd0, req_idx}, 32'd0);
    chk("t5_async_valid", {31'd0, req_valid}, 32'd0);
    do_reset();

    // 6: count=0 never starts; stray responses in IDLE ignored
    scan_count = 8'd0;
    resp_to_ms = 16'd100;
    scan_en    = 1'b1;
    step(5);
    chk("t6_no_req", {31'd0, req_valid}, 32'd0);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    rsp_ok = 1'b1;
    step(1);
    rsp_ok  = 1'b0;
    rsp_err = 1'b1;
    step(1);
    rsp_err = 1'b0;
    step(3);
    chk("t6_errs", {16'd0, scan_err_count}, 32'd0);
    chk("t6_cycles", {16'd0, scan_cycles_done}, 32'd0);
    chk("t6_no_req_after", {31'd0, req_valid}, 32'd0);

    // 7: scan_count above SCAN_MAX is clamped to 16 entries
    do_reset();
    scan_count     = 8'd200;
    scan_period_ms = 16'd0;
    scan_en        = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wait_req(n);
      chk("t7_idx", {24'd0, req_idx}, i);
      respond(2, 1'b1, 1'b0);
    end
    step(1);
    chk("t7_cycle_done", {31'd0, cycle_done}, 32'd1);
    step(1);
    chk("t7_restart_valid", {31'd0, req_valid}, 32'd1);
    chk("t7_restart_idx", {24'd0, req_idx}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
